// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for single-bit sequence detectors: accepts a word on
// load/ready and presents it one bit per clock with per-bit valid, last and hold.
module serial_bit_feeder #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    input  logic             hold,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             last
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_shifted;
    logic [CW-1:0]    cnt;
    logic             head, at_last, advance, accept;

    assign at_last = (cnt == CW'(WIDTH - 1));
    assign advance = (state == SHIFT) && !hold;
    assign accept  = load && ready;

    // Head bit and its successor depend only on the chosen bit order.
    generate
        if (MSB_FIRST) begin : g_msb
            assign head         = sreg[WIDTH-1];
            assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign head         = sreg[0];
            assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (advance && at_last && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Hold masks valid/last/ready but keeps the current bit on the line.
    always_comb begin
        ready     = 1'b1;
        ser_out   = IDLE_BIT;
        ser_valid = 1'b0;
        last      = 1'b0;
        if (state == SHIFT) begin
            ser_out   = head;
            ser_valid = !hold;
            last      = !hold && at_last;
            ready     = !hold && at_last;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (accept) begin
            sreg <= data_in;
            cnt  <= '0;
        end else if (advance) begin
            sreg <= sreg_shifted;
            cnt  <= at_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: MSB-first instance for most scenarios,
// LSB-first instance for bit-order check.
module tb_serial_bit_feeder;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in, data1;
    logic       load, hold, load1, hold1;
    logic       ready, ser_out, ser_valid, last;
    logic       ready1, ser_out1, ser_valid1, last1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u0 (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load), .ready(ready),
        .hold(hold), .ser_out(ser_out), .ser_valid(ser_valid), .last(last)
    );

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u1 (
        .clk(clk), .reset(reset), .data_in(data1), .load(load1), .ready(ready1),
        .hold(hold1), .ser_out(ser_out1), .ser_valid(ser_valid1), .last(last1)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, ser_valid, 1'b0);
        chk({tag, "_last"},  last,      1'b0);
        chk({tag, "_out"},   ser_out,   1'b0);
        chk({tag, "_ready"}, ready,     1'b1);
    endtask

    initial begin
        logic [15:0] seq;
        logic [7:0]  w;
        int          p;

        reset = 1'b0; data_in = '0; load = 1'b0; hold = 1'b0;
        data1 = '0; load1 = 1'b0; hold1 = 1'b0;
        #12;
        chk_idle("rst");
        chk("rst_ready1", ready1, 1'b1);
        @(negedge clk); reset = 1'b1;

        // Single word, MSB first
        w = 8'b1011_0010;
        data_in = w; load = 1'b1;
        tick(); load = 1'b0; data_in = 8'h00; #1;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("w1_out%0d", k),   ser_out,   w[8-k]);
            chk($sformatf("w1_vld%0d", k),   ser_valid, 1'b1);
            chk($sformatf("w1_last%0d", k),  last,      k == 8);
            chk($sformatf("w1_rdy%0d", k),   ready,     k == 8);
            if (k < 8) begin tick(); #1; end
        end
        tick(); #1;
        chk_idle("w1_end");

        // Hold in IDLE leaves ready high
        hold = 1'b1; #1;
        chk("idle_hold_ready", ready, 1'b1);
        chk("idle_hold_valid", ser_valid, 1'b0);
        hold = 1'b0;

        // Back-to-back A5 then 3C
        seq = 16'hA53C;
        data_in = 8'hA5; load = 1'b1;
        tick(); load = 1'b0; #1;
        for (int k = 1; k <= 16; k++) begin
            if (k == 8) begin data_in = 8'h3C; load = 1'b1; end
            else load = 1'b0;
            #1;
            chk($sformatf("b2b_out%0d", k),  ser_out,   seq[16-k]);
            chk($sformatf("b2b_vld%0d", k),  ser_valid, 1'b1);
            chk($sformatf("b2b_last%0d", k), last,      (k == 8) || (k == 16));
            chk($sformatf("b2b_rdy%0d", k),  ready,     (k == 8) || (k == 16));
            if (k < 16) tick();
        end
        load = 1'b0;
        tick(); #1;
        chk_idle("b2b_end");

        // Hold during cycles 3..5 of F0
        w = 8'hF0; p = 0;
        data_in = w; load = 1'b1;
        tick(); load = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            hold = (c >= 3) && (c <= 5);
            #1;
            chk($sformatf("hold_out%0d", c),  ser_out,   w[7-p]);
            chk($sformatf("hold_vld%0d", c),  ser_valid, !hold);
            chk($sformatf("hold_last%0d", c), last,      !hold && p == 7);
            chk($sformatf("hold_rdy%0d", c),  ready,     !hold && p == 7);
            if (!hold) p++;
            if (c < 11) tick();
        end
        hold = 1'b0;
        chk("hold_bitcount", p == 8, 1'b1);
        tick(); #1;
        chk_idle("hold_end");

        // Load with hold on the last bit is refused; last bit re-presented
        data_in = 8'h01; load = 1'b1;
        tick(); load = 1'b0;
        for (int c = 1; c <= 7; c++) tick();
        hold = 1'b1; data_in = 8'hFF; load = 1'b1; #1;
        chk("lasthold_rdy", ready, 1'b0);
        tick(); hold = 1'b0; load = 1'b0; #1;
        chk("lasthold_out",  ser_out,   1'b1);
        chk("lasthold_last", last,      1'b1);
        tick(); #1;
        chk_idle("lasthold_end");

        // Ignored load pulse in cycle 4 of word 00
        data_in = 8'h00; load = 1'b1;
        tick(); load = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) begin data_in = 8'hFF; load = 1'b1; end
            else load = 1'b0;
            #1;
            chk($sformatf("ign_out%0d", k), ser_out,   1'b0);
            chk($sformatf("ign_vld%0d", k), ser_valid, 1'b1);
            if (k < 8) tick();
        end
        load = 1'b0;
        tick(); #1;
        chk_idle("ign_end");

        // Async reset during bit 5 of C3
        data_in = 8'hC3; load = 1'b1;
        tick(); load = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        #1;
        chk("ar_pre_vld", ser_valid, 1'b1);
        chk("ar_pre_out", ser_out,   1'b0);
        #1; reset = 1'b0; #1;
        chk("ar_vld",   ser_valid, 1'b0);
        chk("ar_last",  last,      1'b0);
        chk("ar_out",   ser_out,   1'b0);
        chk("ar_ready", ready,     1'b1);
        tick();
        @(negedge clk); reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick(); #1;
            chk($sformatf("ar_resid_vld%0d", k), ser_valid, 1'b0);
        end

        // First accept right after reset release
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        data_in = 8'h80; load = 1'b1;
        tick(); load = 1'b0; #1;
        chk("rel_out", ser_out,   1'b1);
        chk("rel_vld", ser_valid, 1'b1);
        for (int k = 1; k < 8; k++) tick();

        // LSB-first instance: 0000_0110 -> 0,1,1,0,0,0,0,0
        w = 8'b0000_0110;
        data1 = w; load1 = 1'b1;
        tick(); load1 = 1'b0; #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("lsb_out%0d", k),  ser_out1,   w[k]);
            chk($sformatf("lsb_vld%0d", k),  ser_valid1, 1'b1);
            chk($sformatf("lsb_last%0d", k), last1,      k == 7);
            if (k < 7) tick();
        end
        tick(); #1;
        chk("lsb_end_vld", ser_valid1, 1'b0);
        chk("lsb_end_out", ser_out1,   1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Upstream feeder for the single-bit sequence-detector FSMs in the FSM directory. It accepts a parallel word over a valid/ready handshake and presents it one bit per clock on a serial line, which connects directly to the detector's `in` input. It also provides a per-bit valid, a last-bit marker and a hold input. These let a bench or a higher-level block drive detector stimulus word-by-word instead of from a bit vector.

## Interface
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.
- IDLE_BIT, 0, level driven on `ser_out` when no word is being shifted.

- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- data_in  input  WIDTH  word to serialize; sampled only on an accepted load.
- load  input  1  word-valid request.
- ready  output  1  block can accept a word this cycle; a load is accepted when `load && ready` at a rising edge.
- hold  input  1  freezes shifting while high.
- ser_out  output  1  serial bit; connects to the detector `in` input.
- ser_valid  output  1  `ser_out` carries a new, unconsumed bit this cycle.
- last  output  1  `ser_out` carries the final bit of the word.

## Operation
- State machine has two states.
  - IDLE: `ser_out`=IDLE_BIT, `ser_valid`=0, `last`=0.
  - SHIFT: a shift register holds the word; a bit counter `cnt` of width clog2(WIDTH) runs 0..WIDTH-1.
- Accepted load:
  - Captures `data_in` into the shift register, sets `cnt`=0, moves to SHIFT.
  - `data_in` changes after acceptance have no effect.
- In SHIFT with `hold`=0:
  - `ser_out` = current head bit, `ser_valid`=1.
  - Each edge advances the head by one bit and increments `cnt`.
- `last` = 1 exactly when in SHIFT, `cnt`==WIDTH-1 and `hold`=0.
- `ready` is combinational:
  - 1 in IDLE;
  - 1 in SHIFT when `cnt`==WIDTH-1 and `hold`=0;
  - 0 otherwise.
- End of word, at the edge leaving the last bit:
  - load accepted → back-to-back: next word's first bit on the next cycle, no gap.
  - no load → IDLE.
- `load` while `ready`=0 is ignored. It is not queued; the requester must hold `load` until accepted.
- Hold:
  - `hold`=1 in SHIFT freezes the shift register and `cnt`.
  - `ser_out` keeps the current bit, `ser_valid`=0, `last`=0, `ready`=0.
  - Releasing `hold` resumes from the same bit; no bit is lost or duplicated.
  - `hold` in IDLE has no effect, and `ready` stays 1.
- Bit order:
  - MSB_FIRST=1: sequence is data_in[WIDTH-1] .. data_in[0].
  - MSB_FIRST=0: sequence is data_in[0] .. data_in[WIDTH-1].

## Timing
- Reset values: state IDLE, `ser_out`=IDLE_BIT, `ser_valid`=0, `last`=0, `ready`=1, `cnt`=0, shift register all-zero.
- Latency: first bit is valid in the cycle after the accepting edge.
  - With no hold, a word occupies exactly WIDTH consecutive valid cycles.
  - `last` is in cycle WIDTH after acceptance.
- Throughput: continuous back-to-back loads give 100% bit occupancy, with `ser_valid` never dropping between words.
- `ser_out`, `ser_valid`, `last` and state are registered-state outputs. `ready` and the hold masking are combinational from state and `hold`.
- Reset mid-word aborts immediately: outputs go to reset values asynchronously and no partial word resumes after release.
- First accept is possible on the first rising edge after `reset` deasserts.
- Load and hold on the last-bit cycle: `hold`=1 forces `ready`=0, so the load is not accepted and the last bit is re-presented after release.

## Test plan
- WIDTH=8, MSB_FIRST=1: load 8'b1011_0010 from IDLE → `ser_out` = 1,0,1,1,0,0,1,0 in cycles 1..8 with `ser_valid`=1, `last`=1 only in cycle 8, then IDLE with `ser_out`=0.
- Back-to-back: load 8'hA5, then 8'h3C accepted on the last-bit cycle → 16 consecutive valid bits 1010_0101_0011_1100, `last` in cycles 8 and 16, `ready`=0 in cycles 1..7 and 9..15.
- Hold: load 8'hF0, `hold`=1 during cycles 3..5 → `ser_out` stays 1 with `ser_valid`=0 for 3 cycles, then resumes with bit 5; the full valid sequence is still 1111_0000.
- Ignored load: pulse load with 8'hFF in cycle 4 of word 8'h00 → output stays eight 0s and the pulse is not queued.
- Async reset: assert `reset`=0 mid-edge during bit 5 of 8'hC3 → `ser_valid`=0, `last`=0, `ser_out`=IDLE_BIT without waiting for `clk`, `ready`=1 after release; no residual bits.
- MSB_FIRST=0 driving the detector FSM: load 8'b0000_0110 → serial 0,1,1,0,0,0,0,0. The detector's `out` matches its expected response to that bit stream in every cycle.
